// File: rtl/univ_counter_ctrl.sv
// rtl/univ_counter_ctrl.sv - button/mode front-end producing strobes for a universal up/down counter
// Optional build macro UCC_SAT_EN: manual stepping saturates at the counter boundaries.
module univ_counter_ctrl #(
    parameter int N    = 8,
    parameter int DB_W = 20,
    parameter int PS_W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         btn_up,
    input  logic         btn_dn,
    input  logic         btn_ld,
    input  logic         btn_clr,
    input  logic [N-1:0] sw_d,
    input  logic         mode,
    input  logic         cnt_max,
    input  logic         cnt_min,
    output logic         syn_clr,
    output logic         load,
    output logic         en,
    output logic         up,
    output logic [N-1:0] d,
    output logic         auto_act
);

    typedef enum logic [1:0] {MANUAL, AUTO_UP, AUTO_DN} state_t;

    state_t          state, state_n;
    logic [4:0]      raw, sync1, sync2;
    logic [3:0]      deb, deb_q, req;
    logic            req_up, req_dn, req_ld, req_clr, mode_s;
    logic [PS_W-1:0] ps;
    logic            tick;
    logic            blk_up, blk_dn;
    logic            syn_clr_n, load_n, en_n, up_n;
    logic [N-1:0]    d_n;

    assign raw = {mode, btn_clr, btn_ld, btn_dn, btn_up};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb_q <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
        end
    end

    // The level only flips after 2^DB_W consecutive mismatching clocks.
    for (genvar g = 0; g < 4; g++) begin : g_db
        logic [DB_W-1:0] db_cnt;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                db_cnt <= '0;
                deb[g] <= 1'b0;
            end else if (sync2[g] == deb[g]) begin
                db_cnt <= '0;
            end else if (db_cnt == {DB_W{1'b1}}) begin
                db_cnt <= '0;
                deb[g] <= ~deb[g];
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign req     = deb & ~deb_q;
    assign req_up  = req[0];
    assign req_dn  = req[1];
    assign req_ld  = req[2];
    assign req_clr = req[3];
    assign mode_s  = sync2[4];

    assign tick     = (state != MANUAL) && (ps == {PS_W{1'b1}});
    assign auto_act = (state != MANUAL);

`ifdef UCC_SAT_EN
    assign blk_up = cnt_max;
    assign blk_dn = cnt_min;
`else
    assign blk_up = 1'b0;
    assign blk_dn = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MANUAL;
            ps    <= '0;
        end else begin
            state <= state_n;
            if (state == MANUAL || state_n != state)
                ps <= '0;
            else
                ps <= ps + 1'b1;
        end
    end

    // A tick shared with a clr/ld strobe is swallowed and leaves the state alone.
    always_comb begin
        state_n = state;
        case (state)
            MANUAL:  if (mode_s) state_n = cnt_max ? AUTO_DN : AUTO_UP;
            AUTO_UP: begin
                if (!mode_s)
                    state_n = MANUAL;
                else if (tick && !req_clr && !req_ld && cnt_max)
                    state_n = AUTO_DN;
            end
            AUTO_DN: begin
                if (!mode_s)
                    state_n = MANUAL;
                else if (tick && !req_clr && !req_ld && cnt_min)
                    state_n = AUTO_UP;
            end
            default: state_n = MANUAL;
        endcase
    end

    always_comb begin
        syn_clr_n = 1'b0;
        load_n    = 1'b0;
        en_n      = 1'b0;
        up_n      = up;
        d_n       = d;
        if (req_clr) begin
            syn_clr_n = 1'b1;
        end else if (req_ld) begin
            load_n = 1'b1;
            d_n    = sw_d;
        end else begin
            case (state)
                MANUAL: begin
                    if (req_up) begin
                        if (!blk_up) begin
                            en_n = 1'b1;
                            up_n = 1'b1;
                        end
                    end else if (req_dn) begin
                        if (!blk_dn) begin
                            en_n = 1'b1;
                            up_n = 1'b0;
                        end
                    end
                end
                AUTO_UP: begin
                    if (mode_s && tick) begin
                        en_n = 1'b1;
                        up_n = ~cnt_max;
                    end
                end
                AUTO_DN: begin
                    if (mode_s && tick) begin
                        en_n = 1'b1;
                        up_n = cnt_min;
                    end
                end
                default: en_n = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syn_clr <= 1'b0;
            load    <= 1'b0;
            en      <= 1'b0;
            up      <= 1'b1;
            d       <= '0;
        end else begin
            syn_clr <= syn_clr_n;
            load    <= load_n;
            en      <= en_n;
            up      <= up_n;
            d       <= d_n;
        end
    end

endmodule

// File: tb/tb_univ_counter_ctrl.sv
// tb/tb_univ_counter_ctrl.sv - directed bench for univ_counter_ctrl with a model downstream counter
module tb_univ_counter_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up, btn_dn, btn_ld, btn_clr, mode;
    logic [7:0] sw_d;
    logic       cnt_max, cnt_min;
    logic       syn_clr, load, en, up, auto_act;
    logic [7:0] d;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_clr, n_ld, n_en, first_cyc, clr_cyc;
    logic [7:0] mcnt;

    univ_counter_ctrl #(.N(8), .DB_W(2), .PS_W(3)) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_dn(btn_dn), .btn_ld(btn_ld), .btn_clr(btn_clr),
        .sw_d(sw_d), .mode(mode), .cnt_max(cnt_max), .cnt_min(cnt_min),
        .syn_clr(syn_clr), .load(load), .en(en), .up(up), .d(d), .auto_act(auto_act)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream counter the controller drives.
    always @(posedge clk or negedge reset) begin
        if (!reset)       mcnt <= 8'h00;
        else if (syn_clr) mcnt <= 8'h00;
        else if (load)    mcnt <= d;
        else if (en)      mcnt <= up ? mcnt + 8'h01 : mcnt - 8'h01;
    end
    assign cnt_max = (mcnt == 8'hFF);
    assign cnt_min = (mcnt == 8'h00);

    always @(negedge clk) begin
        if (reset) begin
            if (syn_clr) begin n_clr++; clr_cyc = cyc; if (first_cyc < 0) first_cyc = cyc; end
            if (load)    begin n_ld++;  if (first_cyc < 0) first_cyc = cyc; end
            if (en)      begin n_en++;  if (first_cyc < 0) first_cyc = cyc; end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_mon();
        n_clr = 0; n_ld = 0; n_en = 0; first_cyc = -1; clr_cyc = -1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_en(input int limit, output int c, output logic u);
        c = -1; u = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (en) begin c = cyc; u = up; break; end
        end
    endtask

    task automatic press(input logic [3:0] b, input logic [7:0] v, input int hold);
        sw_d = v;
        {btn_clr, btn_ld, btn_up, btn_dn} = b;
        repeat (hold) @(posedge clk);
        #1;
        {btn_clr, btn_ld, btn_up, btn_dn} = 4'b0000;
        repeat (20) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] btn;   // {clr, ld, up, dn}
        int         hold;
        logic [7:0] swd;
        int         e_clr, e_ld, e_en;
        logic       e_up;
        logic [7:0] e_d;
        int         e_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int c0, c, m0, nd;
        logic u;

        vecs[0] = '{4'b0010,  3, 8'h00, 0, 0, 0, 1'b1, 8'h00, -1};
        vecs[1] = '{4'b0010, 10, 8'h00, 0, 0, 1, 1'b1, 8'h00,  7};
        vecs[2] = '{4'b0001, 10, 8'h00, 0, 0, 1, 1'b0, 8'h00,  7};
        vecs[3] = '{4'b0100, 10, 8'hA5, 0, 1, 0, 1'b0, 8'hA5,  7};
        vecs[4] = '{4'b1100, 10, 8'h3C, 1, 0, 0, 1'b0, 8'hA5,  7};
        vecs[5] = '{4'b0011, 10, 8'h00, 0, 0, 1, 1'b1, 8'hA5,  7};
        vecs[6] = '{4'b0100, 10, 8'hFF, 0, 1, 0, 1'b1, 8'hFF,  7};
`ifdef UCC_SAT_EN
        vecs[7] = '{4'b0010, 10, 8'h00, 0, 0, 0, 1'b1, 8'hFF, -1};
`else
        vecs[7] = '{4'b0010, 10, 8'h00, 0, 0, 1, 1'b1, 8'hFF,  7};
`endif

        reset = 1'b0; mode = 1'b0; sw_d = 8'h00;
        {btn_clr, btn_ld, btn_up, btn_dn} = 4'b1111;
        clear_mon();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_syn_clr", int'(syn_clr), 0);
        check("rst_load", int'(load), 0);
        check("rst_en", int'(en), 0);
        check("rst_up", int'(up), 1);
        check("rst_d", int'(d), 0);
        check("rst_auto_act", int'(auto_act), 0);
        step();
        {btn_clr, btn_ld, btn_up, btn_dn} = 4'b0000;
        reset = 1'b1;
        repeat (3) step();

        // Bouncing button: 2-cycle glitches never qualify, final hold gives one pulse.
        clear_mon();
        for (int k = 0; k < 5; k++) begin
            btn_up = 1'b1; repeat (2) step();
            btn_up = 1'b0; repeat (2) step();
        end
        btn_up = 1'b1; c0 = cyc;
        repeat (12) step();
        btn_up = 1'b0;
        repeat (20) step();
        check("bounce_en_count", n_en, 1);
        check("bounce_latency", first_cyc - c0, 7);
        check("bounce_up", int'(up), 1);

        for (int i = 0; i < 8; i++) begin
            clear_mon();
            c0 = cyc;
            press(vecs[i].btn, vecs[i].swd, vecs[i].hold);
            check($sformatf("v%0d_clr", i), n_clr, vecs[i].e_clr);
            check($sformatf("v%0d_ld", i), n_ld, vecs[i].e_ld);
            check($sformatf("v%0d_en", i), n_en, vecs[i].e_en);
            check($sformatf("v%0d_up", i), int'(up), int'(vecs[i].e_up));
            check($sformatf("v%0d_d", i), int'(d), int'(vecs[i].e_d));
            if (vecs[i].e_lat >= 0)
                check($sformatf("v%0d_latency", i), first_cyc - c0, vecs[i].e_lat);
        end

        // Auto sweep from 0xFD.
        press(4'b0100, 8'hFD, 10);
        mode = 1'b1; m0 = cyc;
        wait_en(20, c, u);
        check("auto_step1_cyc", c - m0, 11);
        check("auto_step1_up", int'(u), 1);
        check("auto_act_on", int'(auto_act), 1);
        wait_en(20, c, u);
        check("auto_step2_cyc", c - m0, 19);
        check("auto_step2_up", int'(u), 1);
        wait_en(20, c, u);
        check("auto_reverse_cyc", c - m0, 27);
        check("auto_reverse_up", int'(u), 0);
        nd = 0;
        for (int k = 0; k < 300; k++) begin
            wait_en(20, c, u);
            if (c < 0 || u) break;
            nd++;
        end
        check("auto_down_steps", nd, 254);
        check("auto_resume_cyc", c - m0, 2067);
        check("auto_resume_up", int'(u), 1);

        // clr lands on the next tick: that tick is consumed.
        step();
        clear_mon();
        c0 = cyc;
        btn_clr = 1'b1;
        wait_en(40, c, u);
        btn_clr = 1'b0;
        check("tick_clr_count", n_clr, 1);
        check("tick_clr_cyc", clr_cyc - c0, 7);
        check("tick_after_clr_cyc", c - c0, 15);
        check("tick_after_clr_up", int'(u), 1);

        step();
        mode = 1'b0;
        clear_mon();
        repeat (30) step();
        check("manual_no_ticks", n_en, 0);
        check("manual_auto_act", int'(auto_act), 0);

        // Enter AUTO_DN directly from the top, then reset mid-sweep.
        press(4'b0100, 8'hFF, 10);
        mode = 1'b1; m0 = cyc;
        wait_en(20, c, u);
        check("autodn_first_cyc", c - m0, 11);
        check("autodn_first_up", int'(u), 0);
        check("autodn_auto_act", int'(auto_act), 1);
        reset = 1'b0;
        #1;
        check("midrst_en", int'(en), 0);
        check("midrst_up", int'(up), 1);
        check("midrst_auto_act", int'(auto_act), 0);
        mode = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        repeat (10) step();
        check("postrst_auto_act", int'(auto_act), 0);
        check("postrst_up", int'(up), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
